// File: rtl/aes_sbox_pkg.sv
// Shared types, constants and GF arithmetic for the composite-field GF((2^4)^2) AES S-box.
// The isomorphism matrices are derived at elaboration from the chosen GF(2^4) and lambda.
package aes_sbox_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  localparam logic [3:0] GF4_POLY     = 4'b0011;  // x^4 + x + 1, x^4 term implied
  // y^2 + y + lambda is irreducible over GF(2^4) because Tr(x^3) = 1
  localparam logic [3:0] GF4_LAMBDA   = 4'b1000;
  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;

  function automatic logic [3:0] gf4_mul_f(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= s;
      s = s[3] ? ({s[2:0], 1'b0} ^ GF4_POLY) : {s[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [3:0] gf4_sq_f(input logic [3:0] q);
    return {q[3], q[3] ^ q[1], q[2], q[2] ^ q[0]};
  endfunction

  // a^-1 = a^14 = a^2 * a^4 * a^8; maps 0 to 0
  function automatic logic [3:0] gf4_inv_f(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_sq_f(a);
    a4 = gf4_sq_f(a2);
    a8 = gf4_sq_f(a4);
    return gf4_mul_f(gf4_mul_f(a2, a4), a8);
  endfunction

  // Composite element {h, l} = h*y + l with y^2 = y + lambda
  function automatic logic [7:0] comp_mul_f(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] ll;
    ll = gf4_mul_f(a[3:0], b[3:0]);
    return {gf4_mul_f(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]) ^ ll,
            gf4_mul_f(gf4_mul_f(a[7:4], b[7:4]), GF4_LAMBDA) ^ ll};
  endfunction

  function automatic logic [7:0] iso_map_f(input logic [7:0] a, input logic [63:0] cols);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) r ^= cols[8*i +: 8];
    end
    return r;
  endfunction

  // Column i is beta^i, where beta is a root of x^8+x^4+x^3+x+1 in the composite field
  function automatic logic [63:0] find_iso_cols();
    logic [7:0]  beta, c, c2, c3, c4, c8, pw;
    logic        found;
    logic [63:0] cols;
    beta  = 8'h02;
    found = 1'b0;
    for (int v = 2; v < 256; v++) begin
      c  = 8'(v);
      c2 = comp_mul_f(c, c);
      c3 = comp_mul_f(c2, c);
      c4 = comp_mul_f(c2, c2);
      c8 = comp_mul_f(c4, c4);
      if (!found && ((c8 ^ c4 ^ c3 ^ c ^ 8'h01) == 8'h00)) begin
        found = 1'b1;
        beta  = c;
      end
    end
    pw   = 8'h01;
    cols = '0;
    for (int i = 0; i < 8; i++) begin
      cols[8*i +: 8] = pw;
      pw = comp_mul_f(pw, beta);
    end
    return cols;
  endfunction

  function automatic logic [63:0] invert_cols(input logic [63:0] cols);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      for (int v = 0; v < 256; v++) begin
        if (iso_map_f(8'(v), cols) == 8'(1 << j)) r[8*j +: 8] = 8'(v);
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_f(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
           ^ AFFINE_C;
  endfunction

  function automatic logic [7:0] inv_affine_f(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ INV_AFFINE_C;
  endfunction

  localparam logic [63:0] ISO_COLS     = find_iso_cols();
  localparam logic [63:0] ISO_INV_COLS = invert_cols(ISO_COLS);

endpackage

// File: rtl/gf4_mul.sv
// GF(2^4) multiplier, field polynomial x^4 + x + 1.
module gf4_mul
  import aes_sbox_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] p_o
);

  always_comb begin
    p_o = gf4_mul_f(a_i, b_i);
  end

endmodule

// File: rtl/sbox_comp_core.sv
// Byte-wide composite-field AES S-box; optional register after the GF(2^4) inversion.
// Inverse S-box path is built only when SBOX_INV_EN is defined.
module sbox_comp_core
  import aes_sbox_pkg::*;
#(
  parameter int unsigned SBOX_PIPE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SBOX_INV_EN
  input  logic              inv_i,
`endif
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] byte_o
);

  logic [7:0] pre, iso, post;
  logic [3:0] h, hl, hl_l, delta, dinv;
  logic [3:0] h_s, hl_s, dinv_s, nh, nl;

`ifdef SBOX_INV_EN
  assign pre = inv_i ? inv_affine_f(byte_i) : byte_i;
`else
  assign pre = byte_i;
`endif

  assign iso   = iso_map_f(pre, ISO_COLS);
  assign h     = iso[7:4];
  assign hl    = iso[7:4] ^ iso[3:0];
  assign delta = gf4_mul_f(gf4_sq_f(h), GF4_LAMBDA) ^ hl_l;
  assign dinv  = gf4_inv_f(delta);

  gf4_mul u_mul_delta (.a_i(hl), .b_i(iso[3:0]), .p_o(hl_l));

  if (SBOX_PIPE != 0) begin : g_pipe
    logic [3:0] h_q, hl_q, dinv_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        h_q    <= '0;
        hl_q   <= '0;
        dinv_q <= '0;
      end else begin
        h_q    <= h;
        hl_q   <= hl;
        dinv_q <= dinv;
      end
    end
    assign h_s    = h_q;
    assign hl_s   = hl_q;
    assign dinv_s = dinv_q;
  end else begin : g_comb
    assign h_s    = h;
    assign hl_s   = hl;
    assign dinv_s = dinv;
  end

  gf4_mul u_mul_hi (.a_i(h_s),  .b_i(dinv_s), .p_o(nh));
  gf4_mul u_mul_lo (.a_i(hl_s), .b_i(dinv_s), .p_o(nl));

  assign post = iso_map_f({nh, nl}, ISO_INV_COLS);

`ifdef SBOX_INV_EN
  assign byte_o = inv_i ? post : affine_f(post);
`else
  assign byte_o = affine_f(post);
`endif

endmodule

// File: rtl/sbox_word_seq.sv
// Byte-serial AES SubWord engine: accepts a word, substitutes its bytes one per cycle.
// Define SBOX_INV_EN to add the inv_i port and inverse S-box mode.
module sbox_word_seq
  import aes_sbox_pkg::*;
#(
  parameter int unsigned SBOX_PIPE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
`ifdef SBOX_INV_EN
  input  logic              inv_i,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, out_q;
  logic [BYTE_W-1:0] core_in, core_out;
  logic              accept, cap_en;
  logic [1:0]        cap_idx;

  assign accept    = (state_q == StIdle) && in_valid;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_word  = out_q;
  assign core_in   = word_q[{cnt_q, 3'b000} +: BYTE_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StFeed;
          cnt_d   = '0;
        end
      end
      StFeed: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = (SBOX_PIPE != 0) ? StDrain : StDone;
      end
      StDrain: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) word_q <= in_word;
      if (cap_en) out_q[{cap_idx, 3'b000} +: BYTE_W] <= core_out;
    end
  end

  // Write side trails the feed side by the core's pipeline depth
  if (SBOX_PIPE != 0) begin : g_cap_reg
    logic       cap_en_q;
    logic [1:0] widx_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cap_en_q <= 1'b0;
        widx_q   <= '0;
      end else begin
        cap_en_q <= (state_q == StFeed);
        widx_q   <= cnt_q;
      end
    end
    assign cap_en  = cap_en_q;
    assign cap_idx = widx_q;
  end else begin : g_cap_comb
    assign cap_en  = (state_q == StFeed);
    assign cap_idx = cnt_q;
  end

`ifdef SBOX_INV_EN
  logic inv_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inv_q <= 1'b0;
    else if (accept) inv_q <= inv_i;
  end
`endif

  sbox_comp_core #(
    .SBOX_PIPE(SBOX_PIPE)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SBOX_INV_EN
    .inv_i (inv_q),
`endif
    .byte_i(core_in),
    .byte_o(core_out)
  );

endmodule

// File: tb/tb_sbox_word_seq.sv
// Self-checking bench for sbox_word_seq against a GF(2^8) reference S-box model.
module tb_sbox_word_seq;

  localparam int unsigned PIPE = 1;
  localparam int LAT = 5 + PIPE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_word;
`ifdef SBOX_INV_EN
  logic        inv = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_ref [256];

  always #5 clk = ~clk;

  sbox_word_seq #(.SBOX_PIPE(PIPE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
`ifdef SBOX_INV_EN
    .inv_i    (inv),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .busy     (busy)
  );

  // Reference: AES field multiply mod 0x11B, brute-force inverse, FIPS-197 affine
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int unsigned p = 0;
    int unsigned x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x << 1;
      if ((x & 256) != 0) x ^= 'h11B;
    end
    return 8'(p);
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] r;
    for (int b = 1; b < 256; b++) if (a != 0 && gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    for (int i = 0; i < 8; i++)
      r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_ref[w[8*k +: 8]];
    return r;
  endfunction

  task automatic send(input logic [31:0] w);
    int n = 0;
    in_word  = w;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send: in_ready stuck at %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called in the cycle right after the accept edge; lat counts cycles from the accept cycle
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    if (out_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_out: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL reset_out_word: got %h want 0", out_word); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_word();
    int lat;
    out_ready = 1'b1;
    send(32'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b want 1", busy); end
    wait_out(lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
    checks++; if (out_word !== 32'h63636363) begin errors++; $display("FAIL zero_word: got %h want 63636363", out_word); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    checks++; if (out_word !== 32'h63636363) begin errors++; $display("FAIL zero_hold: got %h want 63636363", out_word); end
  endtask

  task automatic test_byte_order();
    int lat;
    out_ready = 1'b1;
    send(32'hFF530100);
    wait_out(lat);
    checks++; if (out_word !== 32'h16ED7C63) begin errors++; $display("FAIL byte_order: got %h want 16ed7c63", out_word); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] w = $urandom;
    logic [31:0] exp = sub_word(w);
    out_ready = 1'b0;
    send(w);
    wait_out(lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_word  = ~w;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== exp) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b word=%h want 1/0/%h",
                 c, out_valid, in_ready, out_word, exp);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || out_word !== exp) begin
      errors++; $display("FAIL bp_not_consumed: busy=%b word=%h want 0/%h", busy, out_word, exp);
    end
  endtask

  task automatic test_reset_mid_feed();
    int lat;
    out_ready = 1'b1;
    send($urandom);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_word !== 32'h0) begin
      errors++;
      $display("FAIL midreset_state: out_valid=%b in_ready=%b busy=%b word=%h want 0/1/0/0",
               out_valid, in_ready, busy, out_word);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h01010101);
    wait_out(lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL midreset_latency: got %0d want %0d", lat, LAT); end
    checks++; if (out_word !== 32'h7C7C7C7C) begin errors++; $display("FAIL midreset_word: got %h want 7c7c7c7c", out_word); end
    @(posedge clk); #1;
  endtask

  // 64 back-to-back words covering every byte value once in random order
  task automatic test_sweep(input logic use_inv);
    logic [7:0]  perm [256];
    logic [31:0] win [64];
    logic [31:0] wexp [64];
    logic [7:0]  t;
    int lat, j;
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < 64; k++) begin
      for (int b = 0; b < 4; b++) begin
        win[k][8*b +: 8]  = use_inv ? sbox_ref[perm[4*k+b]] : perm[4*k+b];
        wexp[k][8*b +: 8] = use_inv ? perm[4*k+b] : sbox_ref[perm[4*k+b]];
      end
    end
`ifdef SBOX_INV_EN
    inv = use_inv;
`endif
    out_ready = 1'b1;
    in_word   = win[0];
    in_valid  = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_start: in_ready=%b want 1", in_ready); end
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (k < 63) in_word = win[k+1];
      else in_valid = 1'b0;
      wait_out(lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL sweep_latency word %0d: got %0d want %0d", k, lat, LAT); end
      checks++; if (out_word !== wexp[k]) begin
        errors++; $display("FAIL sweep_word %0d (in %h inv %b): got %h want %h", k, win[k], use_inv, out_word, wexp[k]);
      end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL sweep_gap %0d: in_ready=%b out_valid=%b want 1/0", k, in_ready, out_valid);
      end
    end
`ifdef SBOX_INV_EN
    inv = 1'b0;
`endif
  endtask

`ifdef SBOX_INV_EN
  task automatic test_inverse();
    int lat;
    out_ready = 1'b1;
    inv = 1'b1;
    send(32'h16ED7C63);
    inv = 1'b0;  // held internally for the whole word
    wait_out(lat);
    checks++; if (out_word !== 32'hFF530100) begin errors++; $display("FAIL inverse_word: got %h want ff530100", out_word); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    for (int a = 0; a < 256; a++) sbox_ref[a] = ref_sbox(8'(a));
    test_reset();
    test_zero_word();
    test_byte_order();
    test_backpressure();
    test_reset_mid_feed();
    test_sweep(1'b0);
`ifdef SBOX_INV_EN
    test_inverse();
    test_sweep(1'b1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sbox_word_seq.md
Name: sbox_word_seq

Overview:
- Byte-serial AES SubWord engine for the key-expansion datapath.
- Accepts one 32-bit word over a valid/ready handshake and feeds its four bytes, one per cycle, through a single composite-field GF((2^4)^2) S-box core.
- The core builds on GF(2^4) multipliers with field polynomial x^4+x+1.
- Reassembles the substituted word and presents it downstream with a valid/ready handshake. It sits between the key-word register file and the Rcon/XOR stage.

Parameters:
- SBOX_PIPE, 1, pipeline registers inside the S-box core: 0 = combinational, 1 = one register after GF(2^4) inversion.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  engine can accept a word
- in_word  in  32  input word; byte k = in_word[8k+7:8k]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_word  out  32  substituted word; byte k = S(in byte k)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_word=0, busy=0, byte counter=0, pipe registers=0.
- Reset mid-operation aborts the word. No partial result is ever emitted.
- State IDLE: in_ready=1.
  - On in_valid&&in_ready, latch in_word, clear the feed counter, go to FEED.
- State FEED: in_ready=0.
  - Each cycle, present byte[cnt] to the core; cnt counts 0..3.
  - After cnt=3: go to DRAIN if SBOX_PIPE=1, otherwise go directly to DONE.
- State DRAIN: exactly SBOX_PIPE cycles, collecting the trailing core outputs.
- Core output capture: the result of the byte issued at cycle t is written into out_word[8k+7:8k] at the end of cycle t+SBOX_PIPE. A separate 2-bit write index, trailing the feed index by SBOX_PIPE, selects k.
- State DONE: out_valid=1, out_word stable.
  - On out_ready, go to IDLE next cycle; out_valid drops and in_ready rises.
  - out_word holds its value until the next capture.
- Latency from the accept edge (cycle T) to out_valid high: T+5 for SBOX_PIPE=0, T+6 for SBOX_PIPE=1. There is no overlap between words.
- out_ready held high before DONE has no effect.
- in_valid during a non-IDLE state is ignored; the word is not consumed.
- Back-pressure: DONE persists indefinitely while out_ready=0.
- Function: byte mapping equals the FIPS-197 S-box exactly.
  - Forward path: isomorphic map GF(2^8)→GF((2^4)^2), multiplicative inverse (0 maps to 0), inverse map, affine transform with constant 0x63.
  - The choice of isomorphism matrices is internal, but all 256 values must match FIPS-197.

Optional Feature:
- Macro: SBOX_INV_EN.
- Defined:
  - Adds input port inv_i (1 bit), sampled with in_word at accept and held for the whole word.
  - inv_i=1 selects the inverse S-box: inverse affine (constant 0x05 after matrix), then inversion, then map.
  - inv_i=0 is identical to the forward path.
- Undefined: no inv_i port, forward only, no inverse-affine logic synthesized.

Decomposition:
- Package aes_sbox_pkg holds:
  - state enum: IDLE, FEED, DRAIN, DONE
  - BYTE_W=8, WORD_W=32
  - GF(2^4) polynomial constant 4'b0011 (x^4+x+1)
  - isomorphism and inverse-isomorphism matrix constants
  - AFFINE_C=8'h63, INV_AFFINE_C=8'h05
  - GF(2^4) lambda constant
- One natural sub-module: sbox_comp_core.
  - Byte in, byte out, with the SBOX_PIPE register and the optional inverse path.
  - Instantiates the team's existing GF(2^4) multiplier three times, plus a gf4 squarer and inverse.

Test Plan:
- Reset then in_word=0x00000000, out_ready=1 → out_word=0x63636363, out_valid at T+6 (SBOX_PIPE=1) and T+5 (SBOX_PIPE=0).
- in_word=0xFF530100 → out_word=0x16ED7C63; byte order checked.
- Back-pressure: out_ready=0 for 10 cycles in DONE → out_valid and out_word stable, in_ready=0; in_valid pulsed meanwhile is not accepted.
- rst_n asserted low mid-FEED (cnt=2), released → out_valid=0, in_ready=1. The next word 0x01010101 yields 0x7C7C7C7C with no stale bytes.
- Exhaustive sweep: 64 words covering bytes 0x00..0xFF → every byte matches the FIPS-197 S-box table; back-to-back words with out_ready=1 show a 1-cycle IDLE gap.
- SBOX_INV_EN defined, inv_i=1, in_word=0x16ED7C63 → 0xFF530100; the 256-byte inverse sweep round-trips.
